// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 has priority), NUM_RD combinational
// read ports and a per-register pending scoreboard. Define REGFILE_MP_BYPASS_EN for write-to-read bypass.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wrEn0,
    input  logic [ADDR_W-1:0]          wrAddr0,
    input  logic [DATA_W-1:0]          wrData0,
    input  logic                       wrEn1,
    input  logic [ADDR_W-1:0]          wrAddr1,
    input  logic [DATA_W-1:0]          wrData1,
    input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
    output logic [NUM_RD*DATA_W-1:0]   rdData,
    input  logic                       issueEn,
    input  logic [ADDR_W-1:0]          issueAddr,
    output logic [NUM_RD-1:0]          busy
);

    logic [NUM_REGS*DATA_W-1:0] mem_flat;
    logic [NUM_REGS-1:0]        pend_vec;

    // One storage word plus pending bit per architectural register.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_W-1:0] word_d, word_q;
        logic              pend_d, pend_q;

        always_comb begin
            word_d = word_q;
            pend_d = pend_q;
            if (wrEn0 && wrAddr0 == ADDR_W'(gi)) begin
                word_d = wrData0;
                pend_d = 1'b0;
            end
            if (wrEn1 && wrAddr1 == ADDR_W'(gi)) begin
                word_d = wrData1;
                pend_d = 1'b0;
            end
            // A new producer issued this cycle outranks a retiring writeback.
            if (issueEn && issueAddr == ADDR_W'(gi)) begin
                pend_d = 1'b1;
            end
            if (ZERO_REG != 0 && gi == 0) begin
                word_d = '0;
                pend_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                word_q <= '0;
                pend_q <= 1'b0;
            end else begin
                word_q <= word_d;
                pend_q <= pend_d;
            end
        end

        assign mem_flat[gi*DATA_W +: DATA_W] = word_q;
        assign pend_vec[gi]                  = pend_q;
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign ra = rdAddr[gi*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem_flat[int'(ra)*DATA_W +: DATA_W];
            bsy  = pend_vec[ra];
`ifdef REGFILE_MP_BYPASS_EN
            // Forward in-flight write data; port 1 is applied last so it wins.
            if (!rst) begin
                if (wrEn0 && wrAddr0 == ra) begin
                    data = wrData0;
                    bsy  = 1'b0;
                end
                if (wrEn1 && wrAddr1 == ra) begin
                    data = wrData1;
                    bsy  = 1'b0;
                end
            end
`endif
            if (ZERO_REG != 0 && ra == '0) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rdData[gi*DATA_W +: DATA_W] = data;
        assign busy[gi]                    = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (NUM_RD=4): vector table plus hand sequences for
// reset, bypass and multi-port corners. Expectations follow REGFILE_MP_BYPASS_EN.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int ND = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            wrEn0, wrEn1, issueEn;
    logic [AW-1:0]   wrAddr0, wrAddr1, issueAddr;
    logic [DW-1:0]   wrData0, wrData1;
    logic [ND*AW-1:0] rdAddr;
    logic [ND*DW-1:0] rdData;
    logic [ND-1:0]   busy;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(ND), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
        .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
        .rdAddr(rdAddr), .rdData(rdData),
        .issueEn(issueEn), .issueAddr(issueAddr), .busy(busy)
    );

    typedef struct {
        string       name;
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra;
        logic [31:0] exp_data;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[10];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic idle();
        wrEn0 = 1'b0; wrAddr0 = '0; wrData0 = '0;
        wrEn1 = 1'b0; wrAddr1 = '0; wrData1 = '0;
        issueEn = 1'b0; issueAddr = '0;
    endtask

    function automatic logic [31:0] rd(input int k);
        return rdData[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < NR; a++) begin
            rdAddr = {ND{5'(a)}};
            #1;
            check($sformatf("%s r%0d data p0", tag, a), rd(0), 32'h0);
            check($sformatf("%s r%0d data p3", tag, a), rd(3), 32'h0);
            check($sformatf("%s r%0d busy", tag, a), {28'h0, busy}, 32'h0);
        end
    endtask

    initial begin
        vecs[0] = '{"dual write r5 p1 wins", 1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 0, 5, 32'h22222222, 0};
        vecs[1] = '{"split write r3",        1, 3, 32'h0000000A, 1, 4, 32'h0000000B, 0, 0, 3, 32'h0000000A, 0};
        vecs[2] = '{"split write r4",        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 4, 32'h0000000B, 0};
        vecs[3] = '{"zero reg write+issue",  1, 0, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0};
        vecs[4] = '{"issue r7",              0, 0, 32'h0,        0, 0, 32'h0,        1, 7, 7, 32'h0,        1};
        vecs[5] = '{"writeback r7",          1, 7, 32'h5,        0, 0, 32'h0,        0, 0, 7, 32'h5,        0};
        vecs[6] = '{"issue+write r7",        1, 7, 32'h5,        0, 0, 32'h0,        1, 7, 7, 32'h5,        1};
        vecs[7] = '{"p1 writeback r7",       0, 0, 32'h0,        1, 7, 32'h77,       0, 0, 7, 32'h77,       0};
        vecs[8] = '{"write+issue r2",        1, 2, 32'h1234,     0, 0, 32'h0,        1, 2, 2, 32'h1234,     1};
        vecs[9] = '{"write r6 via p0",       1, 6, 32'h66,       1, 5, 32'h55,       0, 0, 6, 32'h66,       0};

        idle();
        rdAddr = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        for (int i = 0; i < 10; i++) begin
            wrEn0 = vecs[i].we0; wrAddr0 = vecs[i].wa0; wrData0 = vecs[i].wd0;
            wrEn1 = vecs[i].we1; wrAddr1 = vecs[i].wa1; wrData1 = vecs[i].wd1;
            issueEn = vecs[i].ie; issueAddr = vecs[i].ia;
            tick();
            idle();
            rdAddr = {ND{vecs[i].ra}};
            #1;
            check({vecs[i].name, " data"}, rd(0), vecs[i].exp_data);
            check({vecs[i].name, " busy"}, {31'h0, busy[0]}, {31'h0, vecs[i].exp_busy});
        end

        // r5 was rewritten by port 1 in the last vector
        rdAddr = {ND{5'd5}};
        #1;
        check("r5 after p1 rewrite", rd(0), 32'h55);

        // All four ports on the pending r2
        rdAddr = {ND{5'd2}};
        #1;
        for (int k = 0; k < ND; k++) check($sformatf("multiport p%0d data", k), rd(k), 32'h1234);
        check("multiport busy", {28'h0, busy}, 32'hF);

        // Bypass: r9 pending, written this cycle while port 0 reads it
        issueEn = 1'b1; issueAddr = 5'd9;
        tick();
        idle();
        wrEn0 = 1'b1; wrAddr0 = 5'd9; wrData0 = 32'hCAFE0001;
        rdAddr = {5'd0, 5'd0, 5'd10, 5'd9};
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        check("bypass r9 data", rd(0), 32'hCAFE0001);
        check("bypass r9 busy", {31'h0, busy[0]}, 32'h0);
`else
        check("no-bypass r9 data", rd(0), 32'h0);
        check("no-bypass r9 busy", {31'h0, busy[0]}, 32'h1);
`endif
        tick();
        idle();
        #1;
        check("r9 after edge data", rd(0), 32'hCAFE0001);
        check("r9 after edge busy", {31'h0, busy[0]}, 32'h0);

        // Both ports write r10 while port 1 reads it
        wrEn0 = 1'b1; wrAddr0 = 5'd10; wrData0 = 32'h1;
        wrEn1 = 1'b1; wrAddr1 = 5'd10; wrData1 = 32'h2;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        check("bypass r10 p1 priority", rd(1), 32'h2);
`else
        check("no-bypass r10 old", rd(1), 32'h0);
`endif
        check("r9 unaffected p0", rd(0), 32'hCAFE0001);
        tick();
        idle();
        #1;
        check("r10 stored p1 data", rd(1), 32'h2);

        // Reset mid-operation with a pending register and a write in flight
        issueEn = 1'b1; issueAddr = 5'd11;
        tick();
        idle();
        rdAddr = {ND{5'd11}};
        #1;
        check("r11 pending", {31'h0, busy[0]}, 32'h1);
        rst = 1'b1;
        wrEn0 = 1'b1; wrAddr0 = 5'd3; wrData0 = 32'hBAD;
        rdAddr = {ND{5'd3}};
        #1;
        check("rst suppresses bypass r3", rd(0), 32'hA);
        tick();
        rst = 1'b0;
        idle();
        check_all_zero("midreset");

        wrEn0 = 1'b1; wrAddr0 = 5'd11; wrData0 = 32'h33;
        tick();
        idle();
        rdAddr = {ND{5'd11}};
        #1;
        check("r11 after reset data", rd(0), 32'h33);
        check("r11 after reset busy", {31'h0, busy[0]}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
